simmem_wdata_tracker: RTL

SIMMEM_WDATA_TRACKER -- requirements
Module: simmem_wdata_tracker

---
 rtl/simmem_wdata_tracker.sv | 133 +++++++++++++
 1 files changed

// File: rtl/simmem_wdata_tracker.sv
// Pairs accepted write beats with queued write-address bursts and tags each beat with its burst id.
// Beats accepted early (before their address) are counted and released in order once an address arrives.
module simmem_wdata_tracker #(
  parameter int IidWidth    = 4,
  parameter int MaxBurstLen = 16,
  parameter int QueueDepth  = 8,
  parameter int MaxEarly    = MaxBurstLen * QueueDepth,
  localparam int LenW = $clog2(MaxBurstLen + 1),
  localparam int CntW = $clog2(MaxEarly + 1),
  localparam int QW   = $clog2(QueueDepth + 1),
  localparam int PtrW = $clog2(QueueDepth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                waddr_valid_i,
  output logic                waddr_ready_o,
  input  logic [IidWidth-1:0] waddr_iid_i,
  input  logic [LenW-1:0]     waddr_burst_len_i,
  input  logic                wdata_valid_i,
  output logic                wdata_ready_o,
  output logic                beat_valid_o,
  input  logic                beat_ready_i,
  output logic [IidWidth-1:0] beat_iid_o,
  output logic                beat_last_o,
  output logic                burst_done_o,
  output logic [IidWidth-1:0] burst_done_iid_o,
  output logic [CntW-1:0]     early_cnt_o,
  output logic [QW-1:0]       queue_cnt_o,
  output logic                err_o
);

  logic [IidWidth-1:0] iid_q [QueueDepth];
  logic [LenW-1:0]     len_q [QueueDepth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [QW-1:0]       qcnt_q, qcnt_d;
  logic [LenW-1:0]     head_rem_q, head_rem_d;
  logic [CntW-1:0]     early_q, early_d;
  logic                err_q;
  logic                done_q;
  logic [IidWidth-1:0] done_iid_q;

  logic waddr_hs, len_ok, push, wdata_hs, beat_hs, pop;

  assign waddr_ready_o = qcnt_q < QW'(QueueDepth);
  assign wdata_ready_o = early_q < CntW'(MaxEarly);
  assign beat_valid_o  = (early_q != '0) && (qcnt_q != '0);
  assign beat_iid_o    = iid_q[rptr_q];
  assign beat_last_o   = head_rem_q == LenW'(1);

  assign waddr_hs = waddr_valid_i && waddr_ready_o;
  assign len_ok   = (waddr_burst_len_i != '0) && (waddr_burst_len_i <= LenW'(MaxBurstLen));
  assign push     = waddr_hs && len_ok;
  assign wdata_hs = wdata_valid_i && wdata_ready_o;
  assign beat_hs  = beat_valid_o && beat_ready_i;
  assign pop      = beat_hs && beat_last_o;

  assign burst_done_o     = done_q;
  assign burst_done_iid_o = done_iid_q;
  assign early_cnt_o      = early_q;
  assign queue_cnt_o      = qcnt_q;
  assign err_o            = err_q;

  // When the head pops with no successor in memory, an address arriving the same cycle becomes the head.
  always_comb begin
    head_rem_d = head_rem_q;
    if (pop) begin
      if (qcnt_q > QW'(1)) begin
        head_rem_d = len_q[rptr_q + PtrW'(1)];
      end else if (push) begin
        head_rem_d = waddr_burst_len_i;
      end else begin
        head_rem_d = '0;
      end
    end else if (beat_hs) begin
      head_rem_d = head_rem_q - LenW'(1);
    end else if (push && (qcnt_q == '0)) begin
      head_rem_d = waddr_burst_len_i;
    end
  end

  always_comb begin
    early_d = early_q;
    case ({wdata_hs, beat_hs})
      2'b10:   early_d = early_q + CntW'(1);
      2'b01:   early_d = early_q - CntW'(1);
      default: early_d = early_q;
    endcase
  end

  always_comb begin
    qcnt_d = qcnt_q;
    case ({push, pop})
      2'b10:   qcnt_d = qcnt_q + QW'(1);
      2'b01:   qcnt_d = qcnt_q - QW'(1);
      default: qcnt_d = qcnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < QueueDepth; i++) begin
        iid_q[i] <= '0;
        len_q[i] <= '0;
      end
      wptr_q     <= '0;
      rptr_q     <= '0;
      qcnt_q     <= '0;
      head_rem_q <= '0;
      early_q    <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_iid_q <= '0;
    end else begin
      if (push) begin
        iid_q[wptr_q] <= waddr_iid_i;
        len_q[wptr_q] <= waddr_burst_len_i;
        wptr_q        <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      if (waddr_hs && !len_ok) begin
        err_q <= 1'b1;
      end
      done_q     <= pop;
      done_iid_q <= pop ? iid_q[rptr_q] : done_iid_q;
      qcnt_q     <= qcnt_d;
      head_rem_q <= head_rem_d;
      early_q    <= early_d;
    end
  end

endmodule
